lane_wb_buffer: RTL and testbench
=================================

// Module: lane_wb_buffer
// PURPOSE
//  Per-lane writeback buffer. Consumer end of the lane -> writeback interface: it accepts results from one lane and queues them.
//  Queued results drain to a vector register file (VRF) write port through a req/gnt handshake with the shared VRF write arbiter.
//  Drives wb_full_lane back to the lane so that no result is lost while the arbiter stalls this lane.
// PARAMETERS
//  DATA_WIDTH     VECTOR_REG_WIDTH    width of one lane result
//  NUM_VREG       NUM_OF_VECTOR_REG   number of vector registers (tag width = $clog2(NUM_VREG))
//  ELEMS_PER_REG  8                   elements per vector register held by this lane (power of 2, >=2)
//  DEPTH          4                   buffer entries (power of 2, >=2)
// PORTS
//  clk            in   1                     clock
//  reset          in   1                     synchronous, active-high reset
//  result_vld     in   1                     lane result valid this cycle
//  vec_reg_out    in   $clog2(NUM_VREG)      destination vector register of the result
//  data_out       in   DATA_WIDTH            result data
//  wb_full_lane   out  1                     backpressure to lane (lane stops issuing)
//  vrf_wr_req     out  1                     head entry valid, requesting VRF write
//  vrf_wr_reg     out  $clog2(NUM_VREG)      head entry register tag
//  vrf_wr_elem    out  $clog2(ELEMS_PER_REG) head entry element index
//  vrf_wr_data    out  DATA_WIDTH            head entry data
//  vrf_wr_gnt     in   1                     arbiter grant; write completes when req&&gnt
//  empty          out  1                     buffer holds no entries
//  occupancy      out  $clog2(DEPTH)+1       current entry count
//  overflow_err   out  1                     sticky: a result arrived with buffer full and no pop
// BEHAVIOUR
//  - Reset: all entries invalid; occupancy=0, empty=1, vrf_wr_req=0, vrf_wr_reg/elem/data=0, wb_full_lane=0, overflow_err=0.
//    Element tracker is cleared (last_vld=0). Reset mid-drain discards all queued entries; no write is issued in the reset cycle.
//  - Push: result_vld=1 captures {vec_reg_out, elem, data_out} into the tail entry at the clock edge.
//  - Pop: vrf_wr_req && vrf_wr_gnt retires the head entry at the clock edge. gnt while req=0 is ignored.
//  - vrf_wr_req = !empty. vrf_wr_* are driven straight from the head entry register (no combinational path from inputs).
//    A pushed result appears on vrf_wr_* no earlier than the cycle after the push (latency 1 when empty). No bypass.
//  - Requests hold: while req=1 and gnt=0, head reg/elem/data stay stable.
//  - Push and pop in the same cycle: both happen; occupancy unchanged. This is allowed at occupancy==DEPTH (pop frees the slot).
//  - Overflow: push at occupancy==DEPTH without a pop drops the result, sets overflow_err (cleared only by reset), and leaves contents unchanged.
//  - wb_full_lane = (occupancy >= DEPTH-1). Decoded from registered occupancy. The one-entry margin covers the result the lane
//    has in flight when it samples backpressure. A legal lane therefore never causes overflow.
//  - Element index assigned at push:
//    * last_vld && vec_reg_out==last_reg -> elem = last_elem+1, wrapping ELEMS_PER_REG-1 -> 0.
//    * otherwise elem = 0.
//    * After any push: last_reg <= vec_reg_out, last_elem <= elem, last_vld <= 1.
//    * A dropped (overflow) push does not update the tracker.
//  - Pointers: rd_ptr/wr_ptr are $clog2(DEPTH) bits and wrap naturally. occupancy is a separate counter, +1 on push only, -1 on pop only.
//  - empty = (occupancy==0).
// STRUCTURE
//  - Shared package (vector_pkg): VECTOR_REG_WIDTH, NUM_OF_VECTOR_REG, and typedef struct packed wb_entry_t {reg, elem, data}.
//    Reused by the VRF arbiter.
//  - One sub-module: lane_wb_fifo, a generic DEPTH x wb_entry_t synchronous FIFO with push/pop/count/full/empty.
//  - The top level adds the element tracker, the backpressure decode, and the overflow flag.
// TESTING
//  1 Reset, then push reg=3 data=0x11, 0x22, 0x33 on consecutive cycles with gnt=1 -> VRF writes (3,0,0x11),(3,1,0x22),(3,2,0x33),
//    first write on the cycle after the first push; empty=1 afterwards.
//  2 gnt=0, push 3 results (DEPTH=4) -> wb_full_lane=1 once occupancy=3; vrf_wr_* stable; raise gnt -> drains in order, wb_full_lane drops at occupancy 2.
//  3 Fill to 4 with gnt=0, then push with gnt=1 in the same cycle -> occupancy stays 4, overflow_err=0, new entry lands last.
//  4 Fill to 4, gnt=0, push again -> overflow_err=1 and sticky; the dropped data never appears on the VRF port; elem sequence unaffected.
//  5 Push reg=2 x9 (ELEMS_PER_REG=8) -> elems 0..7 then 0. Next push reg=5 -> elem 0. Then reg=2 -> elem 0.
//  6 Assert reset with 3 entries queued and req=1 -> next cycle req=0, occupancy=0, overflow_err=0; the next push gets elem 0.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared vector-unit definitions: register file geometry and the writeback
// entry format that travels from each lane buffer to the VRF write arbiter.
package vector_pkg;

  localparam int VECTOR_REG_WIDTH  = 32;
  localparam int NUM_OF_VECTOR_REG = 32;
  localparam int VREG_TAG_W        = $clog2(NUM_OF_VECTOR_REG);
  localparam int WB_ELEMS_PER_REG  = 8;
  localparam int WB_ELEM_W         = $clog2(WB_ELEMS_PER_REG);

  // One pending VRF write: destination register, element slot, payload.
  typedef struct packed {
    logic [VREG_TAG_W-1:0]       vreg;
    logic [WB_ELEM_W-1:0]        elem;
    logic [VECTOR_REG_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/lane_wb_fifo.sv
// Generic DEPTH-entry synchronous FIFO of writeback entries. Head entry is
// read straight out of the storage registers, so nothing on the input side
// reaches the head output combinationally.
module lane_wb_fifo
  import vector_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  entry_t                   push_data,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_push;
  logic               w_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_pop  = pop && (r_count != CNT_W'(0));
  assign w_push = push && ((r_count != CNT_W'(DEPTH)) || w_pop);

  // Storage, pointers and the entry counter; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == CNT_W'(0));

endmodule

// File: rtl/lane_wb_buffer.sv
// Per-lane writeback buffer: queues lane results, tags each with an element
// index within its destination register, and drains them to the VRF write
// arbiter over req/gnt. Backpressure leaves one slot of margin for the
// result the lane already has in flight when it sees wb_full_lane.
module lane_wb_buffer
  import vector_pkg::*;
#(
  parameter int DATA_WIDTH    = VECTOR_REG_WIDTH,
  parameter int NUM_VREG      = NUM_OF_VECTOR_REG,
  parameter int ELEMS_PER_REG = 8,
  parameter int DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          result_vld,
  input  logic [$clog2(NUM_VREG)-1:0]   vec_reg_out,
  input  logic [DATA_WIDTH-1:0]         data_out,
  output logic                          wb_full_lane,
  output logic                          vrf_wr_req,
  output logic [$clog2(NUM_VREG)-1:0]   vrf_wr_reg,
  output logic [$clog2(ELEMS_PER_REG)-1:0] vrf_wr_elem,
  output logic [DATA_WIDTH-1:0]         vrf_wr_data,
  input  logic                          vrf_wr_gnt,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        occupancy,
  output logic                          overflow_err
);

  localparam int REG_W  = $clog2(NUM_VREG);
  localparam int ELEM_W = $clog2(ELEMS_PER_REG);
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [REG_W-1:0]      vreg;
    logic [ELEM_W-1:0]     elem;
    logic [DATA_WIDTH-1:0] data;
  } lane_entry_t;

  lane_entry_t        w_in_entry;
  lane_entry_t        w_head;
  logic [CNT_W-1:0]   w_count;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [ELEM_W-1:0]  w_elem;

  logic               r_last_vld;
  logic [REG_W-1:0]   r_last_reg;
  logic [ELEM_W-1:0]  r_last_elem;
  logic               r_overflow;

  // Handshake decode: a pop frees a slot for a same-cycle push even when full.
  assign w_pop  = vrf_wr_req && vrf_wr_gnt;
  assign w_push = result_vld && (!w_full || w_pop);
  assign w_drop = result_vld && w_full && !w_pop;

  // Element index: continue the run for a repeated register, else restart at 0.
  always_comb begin
    w_elem = '0;
    if (r_last_vld && (vec_reg_out == r_last_reg)) begin
      w_elem = r_last_elem + ELEM_W'(1);
    end else begin
      w_elem = '0;
    end
  end

  assign w_in_entry = '{vreg: vec_reg_out, elem: w_elem, data: data_out};

  lane_wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (lane_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_in_entry),
    .head      (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  // Element tracker: follows accepted pushes only, dropped results leave it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_vld  <= 1'b0;
      r_last_reg  <= '0;
      r_last_elem <= '0;
    end else if (w_push) begin
      r_last_vld  <= 1'b1;
      r_last_reg  <= vec_reg_out;
      r_last_elem <= w_elem;
    end else begin
      r_last_vld  <= r_last_vld;
      r_last_reg  <= r_last_reg;
      r_last_elem <= r_last_elem;
    end
  end

  // Sticky overflow flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  assign vrf_wr_req   = !w_empty;
  assign vrf_wr_reg   = w_head.vreg;
  assign vrf_wr_elem  = w_head.elem;
  assign vrf_wr_data  = w_head.data;
  assign empty        = w_empty;
  assign occupancy    = w_count;
  assign wb_full_lane = (w_count >= CNT_W'(DEPTH - 1));
  assign overflow_err = r_overflow;

endmodule

// File: tb/tb_lane_wb_buffer.sv
// Scoreboard bench for lane_wb_buffer: stimulus queues the expected VRF
// writes, a negedge monitor compares every req&&gnt beat against the queue.
module tb_lane_wb_buffer;

  localparam int DW = 32;
  localparam int NV = 32;
  localparam int EP = 8;
  localparam int DP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        result_vld;
  logic [4:0]  vec_reg_out;
  logic [31:0] data_out;
  logic        wb_full_lane;
  logic        vrf_wr_req;
  logic [4:0]  vrf_wr_reg;
  logic [2:0]  vrf_wr_elem;
  logic [31:0] vrf_wr_data;
  logic        vrf_wr_gnt;
  logic        empty;
  logic [2:0]  occupancy;
  logic        overflow_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [39:0] exp_q [$];

  always #5 clk = ~clk;

  lane_wb_buffer #(
    .DATA_WIDTH(DW), .NUM_VREG(NV), .ELEMS_PER_REG(EP), .DEPTH(DP)
  ) dut (
    .clk(clk), .reset(reset), .result_vld(result_vld),
    .vec_reg_out(vec_reg_out), .data_out(data_out),
    .wb_full_lane(wb_full_lane), .vrf_wr_req(vrf_wr_req),
    .vrf_wr_reg(vrf_wr_reg), .vrf_wr_elem(vrf_wr_elem),
    .vrf_wr_data(vrf_wr_data), .vrf_wr_gnt(vrf_wr_gnt),
    .empty(empty), .occupancy(occupancy), .overflow_err(overflow_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one result for a cycle; accepted results are queued as expected writes.
  task automatic push(input logic [4:0] r, input logic [31:0] d,
                      input logic [2:0] e, input bit accepted);
    result_vld  = 1'b1;
    vec_reg_out = r;
    data_out    = d;
    if (accepted) exp_q.push_back({r, e, d});
    tick();
    result_vld  = 1'b0;
  endtask

  // Monitor: every completed VRF write must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && vrf_wr_req && vrf_wr_gnt) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {24'd0, vrf_wr_reg, vrf_wr_elem, vrf_wr_data}, 64'hDEAD);
      end else begin
        chk("vrf_write", {24'd0, vrf_wr_reg, vrf_wr_elem, vrf_wr_data},
            {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    reset = 1'b1; result_vld = 1'b0; vec_reg_out = 5'd0; data_out = 32'd0; vrf_wr_gnt = 1'b0;
    tick(); tick();
    reset = 1'b0;
    // Reset state
    chk("rst_occ", occupancy, 3'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_req", vrf_wr_req, 1'b0);
    chk("rst_head", {vrf_wr_reg, vrf_wr_elem, vrf_wr_data}, 40'd0);
    chk("rst_full", wb_full_lane, 1'b0);
    chk("rst_ovf", overflow_err, 1'b0);

    // 1: streaming writes with grant held high
    vrf_wr_gnt = 1'b1;
    push(5'd3, 32'h11, 3'd0, 1'b1);
    chk("t1_req_lat1", vrf_wr_req, 1'b1);
    chk("t1_head0", {vrf_wr_reg, vrf_wr_elem, vrf_wr_data}, {5'd3, 3'd0, 32'h11});
    push(5'd3, 32'h22, 3'd1, 1'b1);
    push(5'd3, 32'h33, 3'd2, 1'b1);
    tick();
    chk("t1_empty", empty, 1'b1);

    // 2: stall, backpressure at 3, drain in order
    vrf_wr_gnt = 1'b0;
    push(5'd4, 32'hA0, 3'd0, 1'b1);
    push(5'd4, 32'hA1, 3'd1, 1'b1);
    chk("t2_full_at2", wb_full_lane, 1'b0);
    chk("t2_hold1", {vrf_wr_reg, vrf_wr_elem, vrf_wr_data}, {5'd4, 3'd0, 32'hA0});
    push(5'd4, 32'hA2, 3'd2, 1'b1);
    chk("t2_occ3", occupancy, 3'd3);
    chk("t2_full_at3", wb_full_lane, 1'b1);
    chk("t2_hold2", {vrf_wr_reg, vrf_wr_elem, vrf_wr_data}, {5'd4, 3'd0, 32'hA0});
    vrf_wr_gnt = 1'b1;
    tick();
    chk("t2_occ2", occupancy, 3'd2);
    chk("t2_full_drop", wb_full_lane, 1'b0);
    tick(); tick();
    chk("t2_empty", empty, 1'b1);

    // 3: push and pop together while full
    vrf_wr_gnt = 1'b0;
    for (int i = 0; i < 4; i++) push(5'd6, 32'hB0 + i, 3'(i), 1'b1);
    chk("t3_occ4", occupancy, 3'd4);
    vrf_wr_gnt = 1'b1;
    push(5'd6, 32'hB4, 3'd4, 1'b1);
    chk("t3_occ_keep", occupancy, 3'd4);
    chk("t3_no_ovf", overflow_err, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk("t3_empty", empty, 1'b1);

    // 4: overflow drops the result and sticks
    vrf_wr_gnt = 1'b0;
    for (int i = 0; i < 4; i++) push(5'd7, 32'hC0 + i, 3'(i), 1'b1);
    push(5'd7, 32'hC4, 3'd4, 1'b0);
    chk("t4_ovf", overflow_err, 1'b1);
    chk("t4_occ", occupancy, 3'd4);
    vrf_wr_gnt = 1'b1;
    tick();
    chk("t4_ovf_sticky", overflow_err, 1'b1);
    push(5'd7, 32'hC5, 3'd4, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    chk("t4_empty", empty, 1'b1);

    // 5: element wrap and register change
    for (int i = 0; i < 9; i++) push(5'd2, 32'hD0 + i, 3'(i % 8), 1'b1);
    push(5'd5, 32'hE0, 3'd0, 1'b1);
    push(5'd2, 32'hE1, 3'd0, 1'b1);
    tick();
    chk("t5_empty", empty, 1'b1);

    // 6: reset mid-drain discards queue and clears tracker
    vrf_wr_gnt = 1'b0;
    push(5'd9, 32'hF0, 3'd0, 1'b0);
    push(5'd9, 32'hF1, 3'd1, 1'b0);
    push(5'd9, 32'hF2, 3'd2, 1'b0);
    chk("t6_req_pre", vrf_wr_req, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_req", vrf_wr_req, 1'b0);
    chk("t6_occ", occupancy, 3'd0);
    chk("t6_ovf", overflow_err, 1'b0);
    vrf_wr_gnt = 1'b1;
    push(5'd9, 32'hF3, 3'd0, 1'b1);
    tick(); tick();
    chk("t6_empty", empty, 1'b1);
    chk("all_writes_seen", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
